// File: rtl/integer_issue_queue.sv
// Integer issue queue: buffers renamed integer instructions from dispatch, tracks source
// readiness from ALU/load broadcasts and the queue's own speculative wakeup, and issues the
// oldest ready entry to the ALU each cycle. Storage is a collapsing age queue (slot 0 = oldest).

package iiq_pkg;
    typedef logic [5:0]  rob_id_t;
    typedef logic [31:0] reg_data_t;

    typedef struct packed {
        logic        src1_valid;
        logic        src1_ready;
        rob_id_t     src1_rob_id;
        reg_data_t   src1_data;
        logic        src2_valid;
        logic        src2_ready;
        rob_id_t     src2_rob_id;
        reg_data_t   src2_data;
        logic        dst_valid;
        rob_id_t     instr_rob_id;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [3:0]  op;
    } iiq_entry_t;
endpackage

module integer_issue_queue
    import iiq_pkg::*;
#(
    parameter int N_ENTRIES = 8
) (
    input  logic       clk,
    input  logic       rst,
    output logic       iiq_dispatch_ready,
    input  logic       iiq_dispatch_valid,
    input  iiq_entry_t iiq_dispatch_data,
    input  logic       alu_issue_ready,
    output logic       alu_issue_valid,
    output iiq_entry_t alu_issue_data,
    output logic       iiq_wakeup_valid,
    output rob_id_t    iiq_wakeup_rob_id,
    input  logic       alu_broadcast_valid,
    input  rob_id_t    alu_broadcast_rob_id,
    input  reg_data_t  alu_broadcast_reg_data,
    input  logic       ld_broadcast_valid,
    input  rob_id_t    ld_broadcast_rob_id,
    input  reg_data_t  ld_broadcast_reg_data,
    input  logic       flush
);
    localparam int CNT_W = $clog2(N_ENTRIES + 1);
    localparam int SEL_W = $clog2(N_ENTRIES);

    iiq_entry_t       slot_q [N_ENTRIES];
    iiq_entry_t       slot_d [N_ENTRIES];
    iiq_entry_t       cap    [N_ENTRIES];
    iiq_entry_t       cap_in;
    iiq_entry_t       sel_entry;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] wr_idx;
    logic [SEL_W-1:0] sel_idx;
    logic             found;
    logic             fire;
    logic             accept;

    // A source is ready when it is not used or its ready bit is already set.
    function automatic logic entry_ready(input iiq_entry_t e);
        return (!e.src1_valid || e.src1_ready) && (!e.src2_valid || e.src2_ready);
    endfunction

    // Apply wakeup and broadcasts to one entry; ALU data overrides load data on a double match.
    function automatic iiq_entry_t capture(
        input iiq_entry_t e,
        input logic wk_v, input rob_id_t wk_id,
        input logic a_v,  input rob_id_t a_id, input reg_data_t a_d,
        input logic l_v,  input rob_id_t l_id, input reg_data_t l_d
    );
        iiq_entry_t r;
        r = e;
        if (e.src1_valid) begin
            if (wk_v && wk_id == e.src1_rob_id) r.src1_ready = 1'b1;
            if (l_v && l_id == e.src1_rob_id) begin r.src1_ready = 1'b1; r.src1_data = l_d; end
            if (a_v && a_id == e.src1_rob_id) begin r.src1_ready = 1'b1; r.src1_data = a_d; end
        end
        if (e.src2_valid) begin
            if (wk_v && wk_id == e.src2_rob_id) r.src2_ready = 1'b1;
            if (l_v && l_id == e.src2_rob_id) begin r.src2_ready = 1'b1; r.src2_data = l_d; end
            if (a_v && a_id == e.src2_rob_id) begin r.src2_ready = 1'b1; r.src2_data = a_d; end
        end
        return r;
    endfunction

    // Dispatch readiness depends only on registered occupancy and reset.
    assign iiq_dispatch_ready = (count_q < CNT_W'(N_ENTRIES)) && !rst;
    assign accept             = iiq_dispatch_valid && iiq_dispatch_ready;

    // Oldest-ready select: scan from the top so the lowest valid ready slot wins.
    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        for (int i = N_ENTRIES - 1; i >= 0; i--) begin
            if (CNT_W'(i) < count_q && entry_ready(slot_q[i])) begin
                found   = 1'b1;
                sel_idx = SEL_W'(i);
            end
        end
    end

    // Issue outputs with same-cycle broadcast bypass on the selected entry's sources.
    always_comb begin
        sel_entry      = slot_q[sel_idx];
        alu_issue_data = sel_entry;
        if (sel_entry.src1_valid) begin
            if (alu_broadcast_valid && alu_broadcast_rob_id == sel_entry.src1_rob_id)
                alu_issue_data.src1_data = alu_broadcast_reg_data;
            else if (ld_broadcast_valid && ld_broadcast_rob_id == sel_entry.src1_rob_id)
                alu_issue_data.src1_data = ld_broadcast_reg_data;
        end
        if (sel_entry.src2_valid) begin
            if (alu_broadcast_valid && alu_broadcast_rob_id == sel_entry.src2_rob_id)
                alu_issue_data.src2_data = alu_broadcast_reg_data;
            else if (ld_broadcast_valid && ld_broadcast_rob_id == sel_entry.src2_rob_id)
                alu_issue_data.src2_data = ld_broadcast_reg_data;
        end
        alu_issue_valid   = found && !flush && !rst;
        fire              = alu_issue_valid && alu_issue_ready;
        iiq_wakeup_valid  = fire && sel_entry.dst_valid;
        iiq_wakeup_rob_id = sel_entry.instr_rob_id;
    end

    // Next-state: capture on every slot and the incoming entry, collapse on issue, append on dispatch.
    always_comb begin
        // NOTE: blocking assignments here build combinational values; only the always_ff blocks use <=.
        for (int i = 0; i < N_ENTRIES; i++) begin
            cap[i] = capture(slot_q[i], iiq_wakeup_valid, iiq_wakeup_rob_id,
                             alu_broadcast_valid, alu_broadcast_rob_id, alu_broadcast_reg_data,
                             ld_broadcast_valid, ld_broadcast_rob_id, ld_broadcast_reg_data);
            slot_d[i] = cap[i];
        end
        cap_in = capture(iiq_dispatch_data, iiq_wakeup_valid, iiq_wakeup_rob_id,
                         alu_broadcast_valid, alu_broadcast_rob_id, alu_broadcast_reg_data,
                         ld_broadcast_valid, ld_broadcast_rob_id, ld_broadcast_reg_data);
        if (fire) begin
            for (int i = 0; i < N_ENTRIES - 1; i++) begin
                if (i >= int'(sel_idx)) slot_d[i] = cap[i + 1];
            end
        end
        wr_idx = count_q - CNT_W'(fire);
        for (int i = 0; i < N_ENTRIES; i++) begin
            if (accept && CNT_W'(i) == wr_idx) slot_d[i] = cap_in;
        end
        if (rst || flush) count_d = '0;
        else              count_d = count_q - CNT_W'(fire) + CNT_W'(accept);
    end

    // Occupancy register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    // Entry storage; slots at or above count are don't-care.
    always_ff @(posedge clk) begin
        // NOTE: the entry array is deliberately not reset; validity comes solely from count_q.
        slot_q <= slot_d;
    end

endmodule

// File: tb/tb_integer_issue_queue.sv
// Directed bench for integer_issue_queue: expected issues go into a scoreboard queue when
// stimulus is applied; a negedge monitor pops and compares on every fired issue.

module tb_integer_issue_queue;
    import iiq_pkg::*;

    typedef struct {
        rob_id_t   rob;
        reg_data_t s1;
        reg_data_t s2;
        logic      wake;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       iiq_dispatch_ready;
    logic       iiq_dispatch_valid;
    iiq_entry_t iiq_dispatch_data;
    logic       alu_issue_ready;
    logic       alu_issue_valid;
    iiq_entry_t alu_issue_data;
    logic       iiq_wakeup_valid;
    rob_id_t    iiq_wakeup_rob_id;
    logic       alu_broadcast_valid;
    rob_id_t    alu_broadcast_rob_id;
    reg_data_t  alu_broadcast_reg_data;
    logic       ld_broadcast_valid;
    rob_id_t    ld_broadcast_rob_id;
    reg_data_t  ld_broadcast_reg_data;
    logic       flush;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    integer_issue_queue #(.N_ENTRIES(8)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .iiq_dispatch_ready     (iiq_dispatch_ready),
        .iiq_dispatch_valid     (iiq_dispatch_valid),
        .iiq_dispatch_data      (iiq_dispatch_data),
        .alu_issue_ready        (alu_issue_ready),
        .alu_issue_valid        (alu_issue_valid),
        .alu_issue_data         (alu_issue_data),
        .iiq_wakeup_valid       (iiq_wakeup_valid),
        .iiq_wakeup_rob_id      (iiq_wakeup_rob_id),
        .alu_broadcast_valid    (alu_broadcast_valid),
        .alu_broadcast_rob_id   (alu_broadcast_rob_id),
        .alu_broadcast_reg_data (alu_broadcast_reg_data),
        .ld_broadcast_valid     (ld_broadcast_valid),
        .ld_broadcast_rob_id    (ld_broadcast_rob_id),
        .ld_broadcast_reg_data  (ld_broadcast_reg_data),
        .flush                  (flush)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic iiq_entry_t mk(input rob_id_t rob, input logic dst,
                                      input logic s1v, input rob_id_t s1id,
                                      input logic s2v, input rob_id_t s2id);
        iiq_entry_t e;
        e              = '0;
        e.instr_rob_id = rob;
        e.dst_valid    = dst;
        e.src1_valid   = s1v;
        e.src1_rob_id  = s1id;
        e.src2_valid   = s2v;
        e.src2_rob_id  = s2id;
        e.pc           = 32'h1000 + 32'(rob);
        return e;
    endfunction

    function automatic exp_t ex(input rob_id_t rob, input reg_data_t s1, input reg_data_t s2,
                                input logic wake);
        exp_t x;
        x.rob  = rob;
        x.s1   = s1;
        x.s2   = s2;
        x.wake = wake;
        return x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Dispatch one entry with no pending sources; caller controls alu_issue_ready.
    task automatic put(input rob_id_t rob);
        iiq_dispatch_valid = 1'b1;
        iiq_dispatch_data  = mk(rob, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
        tick();
        iiq_dispatch_valid = 1'b0;
    endtask

    // Monitor: every fired issue must match the head of the scoreboard.
    always @(negedge clk) begin
        if (alu_issue_valid && alu_issue_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_issue: got rob %0d expected none", alu_issue_data.instr_rob_id);
            end else begin
                exp_t x;
                x = exp_q.pop_front();
                check("issue_rob", 32'(alu_issue_data.instr_rob_id), 32'(x.rob));
                check("issue_src1", alu_issue_data.src1_data, x.s1);
                check("issue_src2", alu_issue_data.src2_data, x.s2);
                check("wakeup_valid", 32'(iiq_wakeup_valid), 32'(x.wake));
                if (x.wake) check("wakeup_rob", 32'(iiq_wakeup_rob_id), 32'(x.rob));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        rst                    = 1'b1;
        iiq_dispatch_valid     = 1'b0;
        iiq_dispatch_data      = '0;
        alu_issue_ready        = 1'b1;
        alu_broadcast_valid    = 1'b0;
        alu_broadcast_rob_id   = '0;
        alu_broadcast_reg_data = '0;
        ld_broadcast_valid     = 1'b0;
        ld_broadcast_rob_id    = '0;
        ld_broadcast_reg_data  = '0;
        flush                  = 1'b0;

        // 1: reset state, then single no-source entry issues the next cycle with wakeup
        tick();
        tick();
        check("rst_dispatch_ready", 32'(iiq_dispatch_ready), 32'd0);
        check("rst_issue_valid", 32'(alu_issue_valid), 32'd0);
        check("rst_wakeup_valid", 32'(iiq_wakeup_valid), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(iiq_dispatch_ready), 32'd1);
        check("post_rst_issue_valid", 32'(alu_issue_valid), 32'd0);
        exp_q.push_back(ex(6'd3, 32'h0, 32'h0, 1'b1));
        put(6'd3);
        check("t1_issue_valid", 32'(alu_issue_valid), 32'd1);
        check("t1_wakeup_rob", 32'(iiq_wakeup_rob_id), 32'd3);
        tick();

        // 2: B waits on rob 3; woken by A's issue, data bypassed from the ALU broadcast
        alu_issue_ready = 1'b0;
        exp_q.push_back(ex(6'd3, 32'h0, 32'h0, 1'b1));
        exp_q.push_back(ex(6'd4, 32'h55, 32'h0, 1'b1));
        put(6'd3);
        iiq_dispatch_valid = 1'b1;
        iiq_dispatch_data  = mk(6'd4, 1'b1, 1'b1, 6'd3, 1'b0, 6'd0);
        tick();
        iiq_dispatch_valid = 1'b0;
        check("t2_stall_rob", 32'(alu_issue_data.instr_rob_id), 32'd3);
        tick();
        check("t2_stable_rob", 32'(alu_issue_data.instr_rob_id), 32'd3);
        alu_issue_ready = 1'b1;
        #1;
        check("t2_wakeup_valid", 32'(iiq_wakeup_valid), 32'd1);
        tick();
        alu_broadcast_valid    = 1'b1;
        alu_broadcast_rob_id   = 6'd3;
        alu_broadcast_reg_data = 32'h55;
        #1;
        check("t2_b_issue_valid", 32'(alu_issue_valid), 32'd1);
        tick();
        alu_broadcast_valid = 1'b0;

        // 3: fill to 8; 9th offered while an issue fires must be ignored
        alu_issue_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(ex(rob_id_t'(10 + i), 32'h0, 32'h0, 1'b1));
            put(rob_id_t'(10 + i));
        end
        check("t3_full_ready", 32'(iiq_dispatch_ready), 32'd0);
        iiq_dispatch_valid = 1'b1;
        iiq_dispatch_data  = mk(6'd18, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
        alu_issue_ready    = 1'b1;
        tick();
        iiq_dispatch_valid = 1'b0;
        alu_issue_ready    = 1'b0;
        check("t3_ready_after_issue", 32'(iiq_dispatch_ready), 32'd1);
        alu_issue_ready = 1'b1;
        repeat (7) tick();
        check("t3_empty_after_drain", 32'(alu_issue_valid), 32'd0);

        // 4: oldest-ready select across a blocked head; ALU beats load on double match
        alu_issue_ready = 1'b0;
        iiq_dispatch_valid = 1'b1;
        iiq_dispatch_data  = mk(6'd20, 1'b1, 1'b1, 6'd40, 1'b0, 6'd0);
        tick();
        iiq_dispatch_valid = 1'b0;
        put(6'd21);
        put(6'd22);
        check("t4_select_slot1", 32'(alu_issue_data.instr_rob_id), 32'd21);
        exp_q.push_back(ex(6'd21, 32'h0, 32'h0, 1'b1));
        exp_q.push_back(ex(6'd22, 32'h0, 32'h0, 1'b1));
        exp_q.push_back(ex(6'd20, 32'hAB, 32'h0, 1'b1));
        alu_issue_ready = 1'b1;
        tick();
        check("t4_select_after_shift", 32'(alu_issue_data.instr_rob_id), 32'd22);
        tick();
        check("t4_head_blocked", 32'(alu_issue_valid), 32'd0);
        alu_broadcast_valid    = 1'b1;
        alu_broadcast_rob_id   = 6'd40;
        alu_broadcast_reg_data = 32'hAB;
        ld_broadcast_valid     = 1'b1;
        ld_broadcast_rob_id    = 6'd40;
        ld_broadcast_reg_data  = 32'hCD;
        tick();
        alu_broadcast_valid = 1'b0;
        ld_broadcast_valid  = 1'b0;
        check("t4_head_woken", 32'(alu_issue_data.instr_rob_id), 32'd20);
        tick();

        // 5: dispatch and issue in the same cycle at count=5 keeps count at 5
        alu_issue_ready = 1'b0;
        for (int i = 0; i < 9; i++) exp_q.push_back(ex(rob_id_t'(30 + i), 32'h0, 32'h0, 1'b1));
        for (int i = 0; i < 5; i++) put(rob_id_t'(30 + i));
        alu_issue_ready = 1'b1;
        put(6'd35);
        alu_issue_ready = 1'b0;
        for (int i = 0; i < 3; i++) put(rob_id_t'(36 + i));
        check("t5_full_after_concurrent", 32'(iiq_dispatch_ready), 32'd0);
        alu_issue_ready = 1'b1;
        repeat (8) tick();
        check("t5_drained", 32'(alu_issue_valid), 32'd0);

        // 7: incoming entry captures a same-cycle ALU broadcast on src2
        exp_q.push_back(ex(6'd50, 32'h0, 32'h77, 1'b0));
        iiq_dispatch_valid     = 1'b1;
        iiq_dispatch_data      = mk(6'd50, 1'b0, 1'b0, 6'd0, 1'b1, 6'd41);
        alu_broadcast_valid    = 1'b1;
        alu_broadcast_rob_id   = 6'd41;
        alu_broadcast_reg_data = 32'h77;
        tick();
        iiq_dispatch_valid  = 1'b0;
        alu_broadcast_valid = 1'b0;
        check("t7_incoming_ready", 32'(alu_issue_valid), 32'd1);
        tick();

        // 6: flush with 4 entries and a concurrent dispatch
        alu_issue_ready = 1'b0;
        for (int i = 0; i < 4; i++) put(rob_id_t'(60 + i));
        flush              = 1'b1;
        iiq_dispatch_valid = 1'b1;
        iiq_dispatch_data  = mk(6'd64, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
        alu_issue_ready    = 1'b1;
        #1;
        check("t6_flush_issue_valid", 32'(alu_issue_valid), 32'd0);
        check("t6_flush_wakeup_valid", 32'(iiq_wakeup_valid), 32'd0);
        tick();
        flush              = 1'b0;
        iiq_dispatch_valid = 1'b0;
        #1;
        check("t6_post_flush_ready", 32'(iiq_dispatch_ready), 32'd1);
        check("t6_post_flush_empty", 32'(alu_issue_valid), 32'd0);
        tick();
        check("t6_dispatch_dropped", 32'(alu_issue_valid), 32'd0);

        // reset mid-operation clears the queue and holds ready low
        alu_issue_ready = 1'b0;
        put(6'd70);
        put(6'd71);
        rst = 1'b1;
        alu_issue_ready = 1'b1;
        #1;
        check("midrst_ready", 32'(iiq_dispatch_ready), 32'd0);
        check("midrst_issue_valid", 32'(alu_issue_valid), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("midrst_after_empty", 32'(alu_issue_valid), 32'd0);
        check("midrst_after_ready", 32'(iiq_dispatch_ready), 32'd1);

        repeat (3) tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
